// File: rtl/lookup_em.sv
// lookup_em: masked-match lookup over a 16-entry key/mask table.
// In-order 3-stage pipeline behind a key FIFO, plus localbus responder.
module lookup_em #(
   parameter int          ENTRY_NUM  = 16,
   parameter logic [15:0] MISS_INDEX = 16'h1FFF,
   parameter int          KEY_ALF_TH = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_lookup_key_wr,
   input  logic [511:0] in_lookup_key,
   output logic         out_lookup_key_alf,
   output logic         out_lookup_index_wr,
   output logic [15:0]  out_lookup_index,
   input  logic         in_lookup_index_alf,
   input  logic         cfg2lookup_cs_n,
   output logic         lookup2cfg_ack_n,
   input  logic         cfg2lookup_rw,
   input  logic [31:0]  cfg2lookup_addr,
   input  logic [31:0]  cfg2lookup_wdata,
   output logic [31:0]  lookup2cfg_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ACK   = 3'd4
   } cfg_st_t;

   logic [511:0] fifo_mem [16];
   logic [3:0]   wr_ptr;
   logic [3:0]   rd_ptr;
   logic [4:0]   usedw;
   logic [4:0]   usedw_nxt;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_push;
   logic         fifo_pop;
   logic         ovf;

   logic                 s0_vld;
   logic [511:0]         s0_key;
   logic [ENTRY_NUM-1:0] hit_c;
   logic                 s1_vld;
   logic [ENTRY_NUM-1:0] s1_hit;
   logic                 enc_hit;
   logic [3:0]           enc_ent;

   logic [511:0]         tkey  [ENTRY_NUM];
   logic [511:0]         tmask [ENTRY_NUM];
   logic [ENTRY_NUM-1:0] tvalid;

   logic [31:0] cnt_kin;
   logic [31:0] cnt_iout;
   logic [31:0] cnt_hit;
   logic [31:0] cnt_miss;

   logic        cs_meta;
   logic        cs;
   cfg_st_t     cfg_st;
   cfg_st_t     cfg_st_nxt;
   logic        ack_n_nxt;
   logic [31:0] rdata_nxt;
   logic [31:0] rd_mux;
   logic        cfg_we;
   logic [11:0] cfg_w;
   logic        tbl_sel;
   logic [3:0]  t_ent;
   logic        t_msk;
   logic [3:0]  t_word;
   logic [8:0]  t_base;
   logic [1:0]  st_lo;
   logic        unused_addr;

   assign unused_addr = ^{cfg2lookup_addr[31:14],
                          cfg2lookup_addr[1:0]};

   // ---------------- key FIFO ----------------
   assign fifo_full  = (usedw == 5'd16);
   assign fifo_empty = (usedw == 5'd0);
   assign fifo_push  = in_lookup_key_wr && !fifo_full;
   assign fifo_pop   = !fifo_empty && !in_lookup_index_alf;

   always_comb begin
      usedw_nxt = usedw;
      if (fifo_push && !fifo_pop)
         usedw_nxt = usedw + 5'd1;
      else if (!fifo_push && fifo_pop)
         usedw_nxt = usedw - 5'd1;
   end

   always_ff @(posedge clk) begin
      if (fifo_push)
         fifo_mem[wr_ptr] <= in_lookup_key;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         usedw              <= '0;
         out_lookup_key_alf <= 1'b0;
      end else begin
         if (fifo_push)
            wr_ptr <= wr_ptr + 4'd1;
         if (fifo_pop)
            rd_ptr <= rd_ptr + 4'd1;
         usedw              <= usedw_nxt;
         out_lookup_key_alf <= (usedw_nxt >= 5'(KEY_ALF_TH));
      end
   end

   // ---------------- match pipeline ----------------
   always_comb begin
      hit_c = '0;
      for (int i = 0; i < ENTRY_NUM; i++)
         hit_c[i] = tvalid[i] &&
                    (((s0_key ^ tkey[i]) & tmask[i]) == '0);
   end

   always_comb begin
      enc_hit = 1'b0;
      enc_ent = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (s1_hit[i]) begin
            enc_hit = 1'b1;
            enc_ent = 4'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_vld              <= 1'b0;
         s0_key              <= '0;
         s1_vld              <= 1'b0;
         s1_hit              <= '0;
         out_lookup_index_wr <= 1'b0;
         out_lookup_index    <= '0;
      end else begin
         s0_vld <= fifo_pop;
         if (fifo_pop)
            s0_key <= fifo_mem[rd_ptr];
         s1_vld              <= s0_vld;
         s1_hit              <= hit_c;
         out_lookup_index_wr <= s1_vld;
         if (s1_vld)
            out_lookup_index <= enc_hit ? {12'b0, enc_ent}
                                        : MISS_INDEX;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_kin  <= '0;
         cnt_iout <= '0;
         cnt_hit  <= '0;
         cnt_miss <= '0;
      end else begin
         if (fifo_push)
            cnt_kin <= cnt_kin + 32'd1;
         if (s1_vld) begin
            cnt_iout <= cnt_iout + 32'd1;
            if (enc_hit)
               cnt_hit <= cnt_hit + 32'd1;
            else
               cnt_miss <= cnt_miss + 32'd1;
         end
      end
   end

   // ---------------- register file ----------------
   assign cfg_w   = cfg2lookup_addr[13:2];
   assign tbl_sel = !cfg_w[11] && (cfg_w[10:9] == 2'b00);
   assign t_ent   = cfg_w[8:5];
   assign t_msk   = cfg_w[4];
   assign t_word  = cfg_w[3:0];
   assign t_base  = {t_word, 5'd0};
   assign cfg_we  = (cfg_st == ST_WRITE);
   assign st_lo   = cfg_st[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            tkey[i]  <= '0;
            tmask[i] <= '0;
         end
         tvalid <= '0;
      end else if (cfg_we) begin
         if (tbl_sel) begin
            if (t_msk)
               tmask[t_ent][t_base +: 32] <= cfg2lookup_wdata;
            else
               tkey[t_ent][t_base +: 32] <= cfg2lookup_wdata;
         end else if (cfg_w == 12'h800) begin
            tvalid <= cfg2lookup_wdata[15:0];
         end
      end
   end

   // Overflow set has priority over a same-cycle software clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (in_lookup_key_wr && fifo_full)
         ovf <= 1'b1;
      else if (cfg_we && cfg_w == 12'h801 &&
               cfg2lookup_wdata[2])
         ovf <= 1'b0;
   end

   always_comb begin
      rd_mux = '0;
      if (!cfg_w[11]) begin
         if (tbl_sel)
            rd_mux = t_msk ? tmask[t_ent][t_base +: 32]
                           : tkey[t_ent][t_base +: 32];
      end else begin
         case (cfg_w)
            12'h800: rd_mux = {16'b0, tvalid};
            12'h801: rd_mux = {st_lo, 27'b0, ovf,
                               out_lookup_key_alf,
                               in_lookup_index_alf};
            12'h802: rd_mux = cnt_kin;
            12'h803: rd_mux = cnt_iout;
            12'h804: rd_mux = cnt_hit;
            12'h805: rd_mux = cnt_miss;
            default: rd_mux = '0;
         endcase
      end
   end

   // ---------------- localbus FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_meta <= 1'b0;
         cs      <= 1'b0;
      end else begin
         cs_meta <= ~cfg2lookup_cs_n;
         cs      <= cs_meta;
      end
   end

   always_comb begin
      cfg_st_nxt = cfg_st;
      ack_n_nxt  = lookup2cfg_ack_n;
      rdata_nxt  = lookup2cfg_rdata;
      case (cfg_st)
         ST_IDLE: begin
            ack_n_nxt = 1'b1;
            rdata_nxt = '0;
            if (cs && lookup2cfg_ack_n)
               cfg_st_nxt = cfg2lookup_rw ? ST_READ : ST_WRITE;
         end
         ST_WRITE: cfg_st_nxt = ST_ACK;
         ST_READ:  cfg_st_nxt = ST_WAIT;
         ST_WAIT:  cfg_st_nxt = ST_ACK;
         ST_ACK: begin
            rdata_nxt = rd_mux;
            if (cs) begin
               ack_n_nxt = 1'b0;
            end else begin
               ack_n_nxt  = 1'b1;
               cfg_st_nxt = ST_IDLE;
            end
         end
         default: cfg_st_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_st           <= ST_IDLE;
         lookup2cfg_ack_n <= 1'b1;
         lookup2cfg_rdata <= '0;
      end else begin
         cfg_st           <= cfg_st_nxt;
         lookup2cfg_ack_n <= ack_n_nxt;
         lookup2cfg_rdata <= rdata_nxt;
      end
   end

endmodule

// File: tb/tb_lookup_em.sv
// tb_lookup_em: scoreboard bench for lookup_em.
// Expected indices come from a bench-side table model.
module tb_lookup_em;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_wr;
   logic [511:0] key;
   logic         key_alf;
   logic         index_wr;
   logic [15:0]  index;
   logic         index_alf;
   logic         cs_n;
   logic         ack_n;
   logic         rw;
   logic [31:0]  addr;
   logic [31:0]  wdata;
   logic [31:0]  rdata;

   int checks   = 0;
   int failures = 0;
   int obs_cnt  = 0;

   logic [15:0]  exp_q [$];
   logic [511:0] mkey  [16];
   logic [511:0] mmask [16];
   logic [15:0]  mvalid;
   logic [31:0]  exp_kin, exp_out, exp_hit, exp_miss;

   always #5 clk = ~clk;

   lookup_em dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .in_lookup_key_wr    (key_wr),
      .in_lookup_key       (key),
      .out_lookup_key_alf  (key_alf),
      .out_lookup_index_wr (index_wr),
      .out_lookup_index    (index),
      .in_lookup_index_alf (index_alf),
      .cfg2lookup_cs_n     (cs_n),
      .lookup2cfg_ack_n    (ack_n),
      .cfg2lookup_rw       (rw),
      .cfg2lookup_addr     (addr),
      .cfg2lookup_wdata    (wdata),
      .lookup2cfg_rdata    (rdata)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_idx(input logic [511:0] k);
      for (int i = 0; i < 16; i++)
         if (mvalid[i] && (((k ^ mkey[i]) & mmask[i]) == '0))
            return 16'(i);
      return 16'h1FFF;
   endfunction

   task automatic expect_key(input logic [511:0] k);
      logic [15:0] e;
      e = model_idx(k);
      exp_q.push_back(e);
      exp_kin++;
      exp_out++;
      if (e == 16'h1FFF) exp_miss++;
      else               exp_hit++;
   endtask

   always @(negedge clk) begin
      if (rst_n && index_wr === 1'b1) begin
         obs_cnt++;
         chk("idx_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0)
            chk("index", {16'b0, index}, {16'b0, exp_q.pop_front()});
      end
   end

   task automatic lb_xfer(input logic [11:0] w, input logic r,
                          input logic [31:0] d,
                          output logic [31:0] q);
      int n;
      @(negedge clk);
      cs_n  = 1'b0;
      rw    = r;
      addr  = {18'b0, w, 2'b00};
      wdata = d;
      n = 0;
      while (ack_n !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("lb_ack", {31'b0, ack_n}, 32'd0);
      q = rdata;
      cs_n = 1'b1;
      n = 0;
      while (ack_n !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("lb_release", {31'b0, ack_n}, 32'd1);
   endtask

   task automatic lb_wr(input logic [11:0] w, input logic [31:0] d);
      logic [31:0] q;
      lb_xfer(w, 1'b0, d, q);
   endtask

   task automatic lb_rd(input logic [11:0] w, output logic [31:0] q);
      lb_xfer(w, 1'b1, 32'd0, q);
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] w,
                         input logic [31:0] m,
                         input logic [31:0] e);
      logic [31:0] q;
      lb_rd(w, q);
      chk(tag, q & m, e);
   endtask

   task automatic tbl_wr(input logic [3:0] e, input logic m,
                         input logic [3:0] wd, input logic [31:0] d);
      lb_wr({1'b0, 2'b00, e, m, wd}, d);
      if (m) mmask[e][32*wd +: 32] = d;
      else   mkey[e][32*wd +: 32]  = d;
   endtask

   task automatic set_valid(input logic [15:0] v);
      lb_wr(12'h800, {16'b0, v});
      mvalid = v;
   endtask

   function automatic logic [511:0] gen_key(input int i);
      if (i % 2 == 0) return 512'h1234;
      return 512'h9000 + 512'(i);
   endfunction

   task automatic burst(input int n, input int acc_n,
                        input bit alf_chk);
      logic [511:0] k;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (alf_chk && i == 11)
            chk("key_alf_11", {31'b0, key_alf}, 32'd0);
         if (alf_chk && i == 12)
            chk("key_alf_12", {31'b0, key_alf}, 32'd1);
         k = gen_key(i);
         key_wr = 1'b1;
         key    = k;
         if (i < acc_n) expect_key(k);
      end
      @(posedge clk);
      #1;
      key_wr = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_counters();
      rd_chk("keys_in", 12'h802, '1, exp_kin);
      rd_chk("idx_out", 12'h803, '1, exp_out);
      rd_chk("hits",    12'h804, '1, exp_hit);
      rd_chk("misses",  12'h805, '1, exp_miss);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      logic [511:0] k;
      rst_n = 1'b0; key_wr = 1'b0; key = '0; index_alf = 1'b0;
      cs_n = 1'b1; rw = 1'b0; addr = '0; wdata = '0;
      for (int i = 0; i < 16; i++) begin
         mkey[i] = '0; mmask[i] = '0;
      end
      mvalid = '0;
      exp_kin = '0; exp_out = '0; exp_hit = '0; exp_miss = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack_n",    {31'b0, ack_n},    32'd1);
      chk("rst_index_wr", {31'b0, index_wr}, 32'd0);
      chk("rst_index",    {16'b0, index},    32'd0);
      chk("rst_key_alf",  {31'b0, key_alf},  32'd0);
      chk("rst_rdata",    rdata,             32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // test 1: single entry, latency
      tbl_wr(4'd3, 1'b0, 4'd0, 32'h1234);
      for (int w = 0; w < 16; w++)
         tbl_wr(4'd3, 1'b1, 4'(w), 32'hFFFF_FFFF);
      set_valid(16'h0008);
      @(posedge clk); #1;
      key_wr = 1'b1; key = 512'h1234;
      expect_key(512'h1234);
      @(posedge clk); #1 key_wr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("lat_early", {31'b0, index_wr}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_3", {31'b0, index_wr}, 32'd1);
      drain();
      rd_chk("hit_cnt_1", 12'h804, '1, 32'd1);

      // test 2: priority between entries 2 and 5
      tbl_wr(4'd2, 1'b0, 4'd0, 32'h0000_ABCD);
      tbl_wr(4'd2, 1'b1, 4'd0, 32'h0000_FFFF);
      tbl_wr(4'd5, 1'b0, 4'd0, 32'h5555_ABCD);
      tbl_wr(4'd5, 1'b0, 4'd1, 32'hDEAD_BEEF);
      for (int w = 0; w < 16; w++)
         tbl_wr(4'd5, 1'b1, 4'(w), 32'hFFFF_FFFF);
      set_valid(16'h002C);
      rd_chk("valid_rb", 12'h800, '1, 32'h2C);
      k = {448'b0, 32'hDEAD_BEEF, 32'h5555_ABCD};
      chk("model_prio", {16'b0, model_idx(k)}, 32'h2);
      @(posedge clk); #1 key_wr = 1'b1; key = k; expect_key(k);
      @(posedge clk); #1 key_wr = 1'b0;
      drain();
      set_valid(16'h0028);
      @(posedge clk); #1 key_wr = 1'b1; key = k; expect_key(k);
      @(posedge clk); #1 key_wr = 1'b0;
      drain();

      // reserved table space and unmapped registers
      lb_wr(12'h260, 32'hFFFF_FFFF);
      rd_chk("resv_rd",  12'h260, '1, 32'd0);
      rd_chk("e3_word0", 12'h060, '1, 32'h1234);
      rd_chk("e5_mask7", 12'h0B7, '1, 32'hFFFF_FFFF);
      rd_chk("unmapped", 12'h806, '1, 32'd0);

      // test 3: 20 back-to-back keys
      burst(20, 20, 1'b0);
      chk("alf_low_t3", {31'b0, key_alf}, 32'd0);
      drain();

      // test 4: downstream backpressure
      base = obs_cnt;
      @(posedge clk); #1 index_alf = 1'b1;
      burst(10, 10, 1'b0);
      repeat (6) @(negedge clk);
      chk("held_no_out", obs_cnt - base, 32'd0);
      @(posedge clk); #1 index_alf = 1'b0;
      drain();
      chk("out_10", obs_cnt - base, 32'd10);

      // test 5: overflow and sticky status
      @(posedge clk); #1 index_alf = 1'b1;
      burst(17, 16, 1'b1);
      rd_chk("status_ovf", 12'h801, 32'h7, 32'h7);
      lb_wr(12'h801, 32'h4);
      rd_chk("status_clr", 12'h801, 32'h7, 32'h3);
      @(posedge clk); #1 index_alf = 1'b0;
      drain();
      rd_chk("status_idle", 12'h801, 32'h7, 32'h0);
      chk_counters();

      // test 6: reset with keys in flight
      @(posedge clk); #1 index_alf = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         key_wr = 1'b1;
         key    = gen_key(i);
      end
      @(posedge clk); #1 key_wr = 1'b0;
      index_alf = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      exp_q.delete();
      exp_kin = '0; exp_out = '0; exp_hit = '0; exp_miss = '0;
      base = obs_cnt;
      @(negedge clk);
      chk("rst2_ack_n", {31'b0, ack_n},    32'd1);
      chk("rst2_idx_wr", {31'b0, index_wr}, 32'd0);
      chk("rst2_index", {16'b0, index},    32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst2_no_out", obs_cnt - base, 32'd0);
      chk_counters();
      rd_chk("rst2_valid", 12'h800, '1, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
